// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard/forwarding controller: default pipeline
// geometry, the register-file forward code and the forward-select width.
package hazard_ctrl_pkg;

  localparam int DEF_PIPE_DEPTH  = 3;
  localparam int DEF_ALU_RDY     = 1;
  localparam int DEF_LOAD_RDY    = 2;
  localparam int FWD_SRC_REGFILE = 0;

  // Select codes 0..pipe_depth: 0 = register file, k = stage k.
  function automatic int sel_w(input int pipe_depth);
    return $clog2(pipe_depth + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard stage: a registered {valid, dst, is_load} writer record.
// It also compares that record against both ID source operands and reports readiness.
module hazard_sb_entry #(
  parameter int ADDR_W   = 5,
  parameter int STAGE    = 1,
  parameter int RDY_ALU  = 1,
  parameter int RDY_LOAD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic              i_is_load,
  input  logic [ADDR_W-1:0] i_rs,
  input  logic              i_rs_used,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic              i_rt_used,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_dst,
  output logic              o_is_load,
  output logic              o_rs_match,
  output logic              o_rt_match,
  output logic              o_ready
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_dst;
  logic              r_is_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_dst     <= '0;
      r_is_load <= 1'b0;
    end else if (i_adv) begin
      r_valid   <= i_valid;
      r_dst     <= i_dst;
      r_is_load <= i_is_load;
    end
  end

  // Register 0 is hard-wired, so it can never be a real dependency.
  assign o_rs_match = i_rs_used & r_valid & (r_dst == i_rs) & (i_rs != '0);
  assign o_rt_match = i_rt_used & r_valid & (r_dst == i_rt) & (i_rt != '0);
  assign o_ready    = r_is_load ? (STAGE >= RDY_LOAD) : (STAGE >= RDY_ALU);

  assign o_valid   = r_valid;
  assign o_dst     = r_dst;
  assign o_is_load = r_is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller beside the ID stage: youngest-match priority over
// the writer scoreboard, stall/bubble/flush/freeze generation and a hazard-stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int  PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int  ADDR_W     = 5,
  parameter int  FWD_EN     = 1,
  parameter int  ALU_RDY    = DEF_ALU_RDY,
  parameter int  LOAD_RDY   = DEF_LOAD_RDY,
  parameter int  CNT_W      = 32,
  localparam int SEL_W      = sel_w(PIPE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic              id_rs_used_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_rt_used_i,
  input  logic              id_we_i,
  input  logic [ADDR_W-1:0] id_dst_i,
  input  logic              id_is_load_i,
  input  logic              branch_taken_i,
  input  logic              ext_stall_i,
  input  logic              clr_cnt_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic              freeze_o,
  output logic [SEL_W-1:0]  fwd_rs_o,
  output logic [SEL_W-1:0]  fwd_rt_o,
  output logic [CNT_W-1:0]  hazard_cnt_o
);

  // Without forwarding nothing becomes ready while it is still tracked.
  localparam int RDY_ALU_EFF  = (FWD_EN != 0) ? ALU_RDY  : PIPE_DEPTH + 1;
  localparam int RDY_LOAD_EFF = (FWD_EN != 0) ? LOAD_RDY : PIPE_DEPTH + 1;

  if (!(ALU_RDY <= LOAD_RDY && LOAD_RDY <= PIPE_DEPTH)) begin : g_bad_cfg
    $error("hazard_ctrl: illegal ALU_RDY/LOAD_RDY/PIPE_DEPTH combination");
  end

  // Index 0 is the ID-stage candidate; 1..PIPE_DEPTH are the tracked stages.
  logic [PIPE_DEPTH:0] w_valid;
  logic [PIPE_DEPTH:0] w_is_load;
  logic [ADDR_W-1:0]   w_dst [0:PIPE_DEPTH];
  logic [PIPE_DEPTH:1] w_rs_match;
  logic [PIPE_DEPTH:1] w_rt_match;
  logic [PIPE_DEPTH:1] w_ready;

  logic             w_adv;
  logic             w_hazard;
  logic             w_rs_hit, w_rs_rdy, w_rt_hit, w_rt_rdy;
  logic [SEL_W-1:0] w_rs_sel, w_rt_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             w_unused_tail;

  assign w_adv        = ~ext_stall_i;
  assign w_valid[0]   = id_valid_i & ~w_hazard & id_we_i & (id_dst_i != '0);
  assign w_dst[0]     = id_dst_i;
  assign w_is_load[0] = id_is_load_i;

  for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_sb
    hazard_sb_entry #(
      .ADDR_W  (ADDR_W),
      .STAGE   (k),
      .RDY_ALU (RDY_ALU_EFF),
      .RDY_LOAD(RDY_LOAD_EFF)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst),
      .i_adv     (w_adv),
      .i_valid   (w_valid[k-1]),
      .i_dst     (w_dst[k-1]),
      .i_is_load (w_is_load[k-1]),
      .i_rs      (id_rs_i),
      .i_rs_used (id_rs_used_i),
      .i_rt      (id_rt_i),
      .i_rt_used (id_rt_used_i),
      .o_valid   (w_valid[k]),
      .o_dst     (w_dst[k]),
      .o_is_load (w_is_load[k]),
      .o_rs_match(w_rs_match[k]),
      .o_rt_match(w_rt_match[k]),
      .o_ready   (w_ready[k])
    );
  end

  // The last stage's record only retires.
  assign w_unused_tail = ^{w_valid[PIPE_DEPTH], w_dst[PIPE_DEPTH], w_is_load[PIPE_DEPTH]};

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    w_rs_hit = 1'b0;
    w_rs_rdy = 1'b0;
    w_rs_sel = SEL_W'(FWD_SRC_REGFILE);
    w_rt_hit = 1'b0;
    w_rt_rdy = 1'b0;
    w_rt_sel = SEL_W'(FWD_SRC_REGFILE);
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (w_rs_match[k]) begin
        w_rs_hit = 1'b1;
        w_rs_rdy = w_ready[k];
        w_rs_sel = SEL_W'(k);
      end
      if (w_rt_match[k]) begin
        w_rt_hit = 1'b1;
        w_rt_rdy = w_ready[k];
        w_rt_sel = SEL_W'(k);
      end
    end
  end

  assign w_hazard = id_valid_i & ((w_rs_hit & ~w_rs_rdy) | (w_rt_hit & ~w_rt_rdy));

  assign freeze_o = ext_stall_i;
  assign stall_o  = freeze_o | w_hazard;
  assign bubble_o = w_hazard & ~freeze_o;
  assign flush_o  = branch_taken_i & ~stall_o;

  assign fwd_rs_o = (FWD_EN != 0 && w_rs_hit && w_rs_rdy) ? w_rs_sel : SEL_W'(FWD_SRC_REGFILE);
  assign fwd_rt_o = (FWD_EN != 0 && w_rt_hit && w_rt_rdy) ? w_rt_sel : SEL_W'(FWD_SRC_REGFILE);

  // bubble_o is already low during a freeze, so frozen cycles are never counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_cnt <= '0;
    end else if (bubble_o && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign hazard_cnt_o = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table on the default build, plus short
// sequences for reset, a no-forwarding build and a 4-bit saturating counter build.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_we, id_is_load;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       branch_taken, ext_stall, clr_cnt;

  logic        d_stall, d_bubble, d_flush, d_freeze;
  logic [1:0]  d_fwd_rs, d_fwd_rt;
  logic [31:0] d_cnt;
  logic        n_stall, n_bubble, n_flush, n_freeze;
  logic [1:0]  n_fwd_rs, n_fwd_rt;
  logic [31:0] n_cnt;
  logic        s_stall, s_bubble, s_flush, s_freeze;
  logic [1:0]  s_fwd_rs, s_fwd_rt;
  logic [3:0]  s_cnt;

  int n_chk;
  int n_err;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic       rs_u;
    logic [4:0] rt;
    logic       rt_u;
    logic       we;
    logic [4:0] dst;
    logic       ld;
    logic       br;
    logic       ext;
    logic       clr;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs[$];

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_used_i(id_rs_used),
    .id_rt_i(id_rt), .id_rt_used_i(id_rt_used), .id_we_i(id_we), .id_dst_i(id_dst),
    .id_is_load_i(id_is_load), .branch_taken_i(branch_taken), .ext_stall_i(ext_stall),
    .clr_cnt_i(clr_cnt), .stall_o(d_stall), .bubble_o(d_bubble), .flush_o(d_flush),
    .freeze_o(d_freeze), .fwd_rs_o(d_fwd_rs), .fwd_rt_o(d_fwd_rt), .hazard_cnt_o(d_cnt)
  );

  hazard_ctrl #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_used_i(id_rs_used),
    .id_rt_i(id_rt), .id_rt_used_i(id_rt_used), .id_we_i(id_we), .id_dst_i(id_dst),
    .id_is_load_i(id_is_load), .branch_taken_i(branch_taken), .ext_stall_i(ext_stall),
    .clr_cnt_i(clr_cnt), .stall_o(n_stall), .bubble_o(n_bubble), .flush_o(n_flush),
    .freeze_o(n_freeze), .fwd_rs_o(n_fwd_rs), .fwd_rt_o(n_fwd_rt), .hazard_cnt_o(n_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_used_i(id_rs_used),
    .id_rt_i(id_rt), .id_rt_used_i(id_rt_used), .id_we_i(id_we), .id_dst_i(id_dst),
    .id_is_load_i(id_is_load), .branch_taken_i(branch_taken), .ext_stall_i(ext_stall),
    .clr_cnt_i(clr_cnt), .stall_o(s_stall), .bubble_o(s_bubble), .flush_o(s_flush),
    .freeze_o(s_freeze), .fwd_rs_o(s_fwd_rs), .fwd_rt_o(s_fwd_rt), .hazard_cnt_o(s_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] pk(input logic st, bu, fl, fr, input logic [1:0] a, b,
                                     input logic [31:0] c);
    return {st, bu, fl, fr, a, b, c};
  endfunction

  function automatic vec_t mk(input logic valid, input int rs, input logic rs_u, input int rt,
                              input logic rt_u, input logic we, input int dst, input logic ld,
                              input logic br, input logic ext, input logic clr,
                              input logic st, bu, fl, fr, input int a, b, c);
    vec_t v;
    v.valid = valid; v.rs = 5'(rs); v.rs_u = rs_u; v.rt = 5'(rt); v.rt_u = rt_u;
    v.we = we; v.dst = 5'(dst); v.ld = ld; v.br = br; v.ext = ext; v.clr = clr;
    v.exp = pk(st, bu, fl, fr, 2'(a), 2'(b), 32'(c));
    return v;
  endfunction

  // Driver tasks
  task automatic set_id(input logic valid, input int rs, input logic rs_u, input int rt,
                        input logic rt_u, input logic we, input int dst, input logic ld);
    id_valid = valid; id_rs = 5'(rs); id_rs_used = rs_u; id_rt = 5'(rt); id_rt_used = rt_u;
    id_we = we; id_dst = 5'(dst); id_is_load = ld;
    branch_taken = 1'b0; ext_stall = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    set_id(v.valid, int'(v.rs), v.rs_u, int'(v.rt), v.rt_u, v.we, int'(v.dst), v.ld);
    branch_taken = v.br; ext_stall = v.ext; clr_cnt = v.clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  // Scoreboard compare
  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] d_pk();
    return pk(d_stall, d_bubble, d_flush, d_freeze, d_fwd_rs, d_fwd_rt, d_cnt);
  endfunction

  function automatic logic [39:0] n_pk();
    return pk(n_stall, n_bubble, n_flush, n_freeze, n_fwd_rs, n_fwd_rt, n_cnt);
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);

    // Fields: valid rs rs_u rt rt_u we dst ld br ext clr | stall bubble flush freeze fwd_rs fwd_rt cnt
    vecs.push_back(mk(1, 5, 1, 6, 1, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 1, 2, 1, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 3, 1, 0, 0, 1, 4, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4, 1, 2, 1, 1, 5, 0, 0, 0, 0,  1, 1, 0, 0, 0, 3, 0));
    vecs.push_back(mk(1, 4, 1, 2, 1, 1, 5, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 6, 1, 5, 1, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 6, 1, 5, 1, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 2, 3, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 7, 1, 7, 1, 1, 8, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 2));
    vecs.push_back(mk(1, 7, 1, 7, 1, 1, 8, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 7, 1, 7, 1, 1, 8, 0, 0, 0, 0,  0, 0, 0, 0, 2, 2, 3));
    vecs.push_back(mk(1, 8, 1, 0, 0, 1, 9, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(1, 9, 1, 0, 1, 1, 10, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 9, 1, 0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 10, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
    vecs.push_back(mk(1, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 11, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_state", d_pk(), pk(0, 0, 0, 0, 2'd0, 2'd0, 32'd0));
    step();

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), d_pk(), vecs[i].exp);
      step();
    end

    // Asynchronous reset while a load-use stall is pending, counter nonzero.
    set_id(1, 0, 0, 0, 0, 1, 2, 1); step();
    set_id(1, 2, 1, 4, 1, 1, 3, 0); step(); step();
    set_id(1, 0, 0, 0, 0, 1, 2, 1); step();
    set_id(1, 2, 1, 4, 1, 1, 3, 0);
    @(negedge clk);
    chk("pre_reset", d_pk(), pk(1, 1, 0, 0, 2'd0, 2'd0, 32'd1));
    #1 rst = 1'b0;
    #1 chk("in_reset", d_pk(), pk(0, 0, 0, 0, 2'd0, 2'd0, 32'd0));
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_reset", d_pk(), pk(0, 0, 0, 0, 2'd0, 2'd0, 32'd0));
    step();

    // No-forwarding build: ALU writer then dependent taken branch.
    reset_all();
    set_id(1, 5, 1, 6, 1, 1, 2, 0);
    @(negedge clk);
    chk("nofwd_writer", n_pk(), pk(0, 0, 0, 0, 2'd0, 2'd0, 32'd0));
    step();
    set_id(1, 2, 1, 0, 1, 0, 0, 0);
    branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("nofwd_stall%0d", i), n_pk(), pk(1, 1, 0, 0, 2'd0, 2'd0, 32'(i)));
      step();
    end
    @(negedge clk);
    chk("nofwd_release", n_pk(), pk(0, 0, 1, 0, 2'd0, 2'd0, 32'd3));
    step();

    // No-forwarding build: rs and rt depend on writers in different stages.
    set_id(1, 0, 0, 0, 0, 1, 2, 0); step();
    set_id(1, 0, 0, 0, 0, 1, 3, 0); step();
    set_id(1, 3, 1, 2, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("nofwd_dual%0d", i), n_pk(),
          (i < 3) ? pk(1, 1, 0, 0, 2'd0, 2'd0, 32'(3 + i)) : pk(0, 0, 0, 0, 2'd0, 2'd0, 32'd6));
      step();
    end

    // 4-bit counter build: saturation, then clear during a bubble.
    reset_all();
    for (int p = 0; p < 20; p++) begin
      set_id(1, 0, 0, 0, 0, 1, 2, 1); step();
      set_id(1, 2, 1, 4, 1, 1, 3, 0); step(); step();
    end
    @(negedge clk);
    chk("sat_hold", 40'(s_cnt), 40'd15);
    step();
    set_id(1, 0, 0, 0, 0, 1, 2, 1); step();
    set_id(1, 2, 1, 4, 1, 1, 3, 0);
    clr_cnt = 1'b1;
    @(negedge clk);
    chk("sat_clr_bubble", {39'd0, s_bubble}, 40'd1);
    step();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("sat_cleared", 40'(s_cnt), 40'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It replaces the single hard-wired pause signal.
- Tracks in-flight register writers in a scoreboard of PIPE_DEPTH stages after ID.
- For each ID-stage instruction it produces forwarding selects, interlock stalls, bubble insertion, IF/ID flush and a global freeze.
- Sits beside the ID stage. Its outputs drive PC hold, the IF/ID, ID/EXE, EXE/MEM and MEM/WB hold/clear inputs, and the ID operand forwarding muxes.

Parameters:
- PIPE_DEPTH, 3: number of tracked stages after ID (1=EX .. PIPE_DEPTH=WB).
- ADDR_W, 5: register address width.
- FWD_EN, 1: 1 = forwarding enabled; 0 = pure interlock, where every dependency stalls until the writer leaves stage PIPE_DEPTH.
- ALU_RDY, 1: first stage index at which a non-load result is forwardable.
- LOAD_RDY, 2: first stage index at which a load result is forwardable.
- CNT_W, 32: width of the hazard stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  ADDR_W  source rs.
- id_rs_used_i  in  1  rs is read.
- id_rt_i  in  ADDR_W  source rt.
- id_rt_used_i  in  1  rt is read.
- id_we_i  in  1  instruction writes a register.
- id_dst_i  in  ADDR_W  destination register.
- id_is_load_i  in  1  instruction is a load.
- branch_taken_i  in  1  ID resolved a taken branch/jump.
- ext_stall_i  in  1  external multi-cycle stall request.
- clr_cnt_i  in  1  synchronous clear of hazard_cnt_o.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  load a NOP into ID/EXE.
- flush_o  out  1  clear IF/ID.
- freeze_o  out  1  hold every pipeline register.
- fwd_rs_o  out  SEL_W  rs source: 0 = register file, k = stage k. SEL_W = $clog2(PIPE_DEPTH+1).
- fwd_rt_o  out  SEL_W  rt source, same encoding.
- hazard_cnt_o  out  CNT_W  count of hazard-stall cycles.

Behaviour:
- Scoreboard entry per stage k: {valid, dst, is_load}.
  - Only instructions with we=1 and dst!=0 enter as valid.
  - Register 0 never matches a source.
- Match: a source is used, equals the entry's dst, and the entry is valid. The youngest match (lowest k) governs.
- Ready stage:
  - FWD_EN=1: LOAD_RDY if is_load, else ALU_RDY.
  - FWD_EN=0: PIPE_DEPTH+1 (never ready while tracked).
- hz (per source): the governing match exists and k < ready stage.
- fwd_*_o: k if the governing match exists and is ready, else 0. Forced to 0 when FWD_EN=0.
- freeze_o = ext_stall_i.
- hazard = id_valid_i & (hz_rs | hz_rt).
- stall_o = freeze_o | hazard.
- bubble_o = hazard & ~freeze_o.
- flush_o = branch_taken_i & ~stall_o. A branch blocked by a stall is re-evaluated after the stall.
- All outputs above are combinational from scoreboard and ID inputs.
- Sequential update on the rising clk edge:
  - If freeze_o: scoreboard holds.
  - Else: entry k+1 <= entry k for k = 1..PIPE_DEPTH-1, and entry PIPE_DEPTH retires.
  - Entry 1 <= ID instruction if id_valid_i & ~hazard & id_we_i & dst!=0, else invalid (bubble).
- hazard_cnt_o:
  - Increments when bubble_o=1 and saturates at all-ones.
  - clr_cnt_i has priority over increment.
  - Freeze cycles are not counted.
- Reset (rst=0, asynchronous, any time including mid-stall): all entries invalid and hazard_cnt_o = 0. Outputs then read stall_o = bubble_o = flush_o = 0, fwd = 0; freeze_o follows ext_stall_i.
- Simultaneous events:
  - ext_stall together with a hazard: freeze dominates, no bubble.
  - branch_taken together with a hazard: no flush.
  - rs and rt hazards on different stages: stall until both clear.
- Legality: ALU_RDY <= LOAD_RDY <= PIPE_DEPTH is checked by an elaboration-time assertion.

Decomposition:
- Shared package (const.vh style): SEL_W computation, FWD_SRC_REGFILE = 0, default PIPE_DEPTH, ALU_RDY and LOAD_RDY constants.
- One natural sub-module: hazard_sb_entry, holding one scoreboard stage's register and the compare/ready logic. It is generated PIPE_DEPTH times; the top module does youngest-match priority and the counter.

Test Plan:
- Reset values: assert rst=0 mid-stream with a load in stage 1 -> next cycle all entries invalid, stall_o=0, fwd=0, hazard_cnt_o=0.
- ALU chain: addu $2 then addu $3,$2,$2 (defaults) -> no stall, fwd_rs_o=fwd_rt_o=1.
- Load-use: lw $2 then addu $3,$2,$4 -> one cycle with stall_o=bubble_o=1 and fwd_rs_o=0, then fwd_rs_o=2, fwd_rt_o=0, hazard_cnt_o=1.
- FWD_EN=0 build, addu $2 then beq $2,$0 -> stall for 3 cycles, fwd always 0, hazard_cnt_o=3; branch_taken_i during the stall gives flush_o=0, then flush_o=1 on the first non-stalled cycle.
- ext_stall_i=1 for 4 cycles with a load in stage 1 -> freeze_o=1, scoreboard unchanged, hazard_cnt_o unchanged; after release the load advances normally.
- Counter saturation with CNT_W=4: 20 load-use pairs -> hazard_cnt_o holds at 15; clr_cnt_i during a bubble cycle -> 0.
